seq_run_reporter: RTL and testbench

- Downstream consumer of the 1111/0000 sequence detector's level output z.
- Each contiguous high run of z is one detection run. The block turns each run into one event record holding the run length.
- Records go out on a single-entry valid/ready port. The block also keeps a saturating total-run count and a sticky overrun flag for the status/CSR layer.

---
 rtl/seq_run_reporter.sv | 146 ++++++++++++++
 tb/tb_seq_run_reporter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_run_reporter.sv
// seq_run_reporter: turns each contiguous high run of the detector output z
// into one event record {evt_len[, evt_ts]} on a single-entry valid/ready
// slot, and keeps a saturating completed-run counter plus a sticky overrun flag.
//
// Optional build macro: SEQ_EVT_TIMESTAMP_EN adds a free-running timestamp
// counter and the evt_ts output, stamped on the completion edge.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | z low, no run in progress, len = 0
// RUN   | z has been high since the last IDLE->RUN edge, len counts it
module seq_run_reporter #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 16,
    parameter int TS_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             z,
    input  logic             clr,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [LEN_W-1:0] evt_len,
    output logic [CNT_W-1:0] run_count,
    output logic             overrun
`ifdef SEQ_EVT_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]  evt_ts
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_next;
    logic             complete;
    logic             load;

    // Next-state and run-length logic; a completion is the z=0 sample in RUN.
    always_comb begin
        state_next = state;
        len_next   = len;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (z) begin
                    state_next = RUN;
                    len_next   = LEN_W'(1);
                end
            end
            RUN: begin
                if (z) begin
                    if (len != LEN_MAX) begin
                        len_next = len + 1'b1;
                    end
                end else begin
                    state_next = IDLE;
                    len_next   = '0;
                    complete   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                len_next   = '0;
            end
        endcase
    end

    // A finished run fits if the slot is empty or is being drained this edge.
    assign load = complete && (!evt_valid || evt_ready);

    // FSM state and run-length register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            len   <= '0;
        end else if (clr) begin
            state <= IDLE;
            len   <= '0;
        end else begin
            state <= state_next;
            len   <= len_next;
        end
    end

    // Event slot, completed-run counter and sticky overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_valid <= 1'b0;
            evt_len   <= '0;
            run_count <= '0;
            overrun   <= 1'b0;
        end else if (clr) begin
            evt_valid <= 1'b0;
            evt_len   <= '0;
            run_count <= '0;
            overrun   <= 1'b0;
        end else begin
            if (complete && (run_count != CNT_MAX)) begin
                run_count <= run_count + 1'b1;
            end
            if (load) begin
                evt_valid <= 1'b1;
                evt_len   <= len;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
            if (complete && !load) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef SEQ_EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_next;

    // The stamp is the counter value as it stands after the completion edge.
    assign ts_next = ts_cnt + 1'b1;

    // Free-running wrapping timestamp and the stamped copy held in the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt <= '0;
            evt_ts <= '0;
        end else if (clr) begin
            ts_cnt <= '0;
            evt_ts <= '0;
        end else begin
            ts_cnt <= ts_next;
            if (load) begin
                evt_ts <= ts_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_run_reporter.sv
// Self-checking bench for seq_run_reporter: reset/table/corner sequences,
// a small-width instance for saturation, and a randomized run against a
// run-level reference model.
module tb_seq_run_reporter;

    localparam int LEN_W = 8;
    localparam int CNT_W = 16;
    localparam int TS_W  = 16;
    localparam int LMAX  = (1 << LEN_W) - 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             z = 1'b0;
    logic             clr = 1'b0;
    logic             evt_ready = 1'b0;
    logic             evt_valid;
    logic [LEN_W-1:0] evt_len;
    logic [CNT_W-1:0] run_count;
    logic             overrun;

    logic             z_s = 1'b0;
    logic             clr_s = 1'b0;
    logic             rdy_s = 1'b1;
    logic             valid_s;
    logic [3:0]       len_s;
    logic [1:0]       cnt_s;
    logic             ovr_s;

`ifdef SEQ_EVT_TIMESTAMP_EN
    logic [TS_W-1:0]  evt_ts;
    logic [TS_W-1:0]  ts_s;
`endif

    seq_run_reporter #(.LEN_W(LEN_W), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
        .clk(clk), .reset(reset), .z(z), .clr(clr),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_len(evt_len),
        .run_count(run_count), .overrun(overrun)
`ifdef SEQ_EVT_TIMESTAMP_EN
        , .evt_ts(evt_ts)
`endif
    );

    seq_run_reporter #(.LEN_W(4), .CNT_W(2), .TS_W(TS_W)) dut_s (
        .clk(clk), .reset(reset), .z(z_s), .clr(clr_s),
        .evt_valid(valid_s), .evt_ready(rdy_s), .evt_len(len_s),
        .run_count(cnt_s), .overrun(ovr_s)
`ifdef SEQ_EVT_TIMESTAMP_EN
        , .evt_ts(ts_s)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: tracks runs as plain integers, clamps on output.
    bit m_in_run, m_full, m_ovr;
    int m_run, m_len, m_runs, m_ts, m_ts_len;

    function automatic void model_clear();
        m_in_run = 0; m_full = 0; m_ovr = 0;
        m_run = 0; m_len = 0; m_runs = 0; m_ts = 0; m_ts_len = 0;
    endfunction

    function automatic void model_edge(bit zi, bit ri, bit ci);
        bit comp;
        if (ci) begin
            model_clear();
            return;
        end
        m_ts = (m_ts + 1) % (1 << TS_W);
        comp = m_in_run && !zi;
        if (m_full && ri) m_full = 0;
        if (comp) begin
            if (m_runs < CMAX) m_runs++;
            if (!m_full) begin
                m_full = 1;
                m_len = (m_run > LMAX) ? LMAX : m_run;
                m_ts_len = m_ts;
            end else begin
                m_ovr = 1;
            end
        end
        if (zi) begin
            m_in_run = 1;
            m_run++;
        end else begin
            m_in_run = 0;
            m_run = 0;
        end
    endfunction

    task automatic tick();
        if (reset) model_clear();
        else model_edge(z, evt_ready, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, int'(evt_valid), int'(m_full));
        if (m_full) check({tag, ".len"}, int'(evt_len), m_len);
        check({tag, ".count"}, int'(run_count), m_runs);
        check({tag, ".overrun"}, int'(overrun), int'(m_ovr));
`ifdef SEQ_EVT_TIMESTAMP_EN
        if (m_full) check({tag, ".ts"}, int'(evt_ts), m_ts_len);
`endif
    endtask

    typedef struct {
        bit zi;
        bit ri;
        bit ci;
        bit v;
        int len;
        int cnt;
        bit ovr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit zi, bit ri, bit ci, bit v, int len, int cnt, bit ovr, int rep);
        vec_t t;
        t.zi = zi; t.ri = ri; t.ci = ci; t.v = v; t.len = len; t.cnt = cnt; t.ovr = ovr;
        for (int i = 0; i < rep; i++) tbl.push_back(t);
    endfunction

    initial begin
        // single run of 4 with ready high
        add(0, 0, 1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 4);
        add(0, 1, 0, 1, 4, 1, 0, 1);
        add(0, 1, 0, 0, 0, 1, 0, 1);
        // backpressure: runs of 5 then 2, second one dropped
        add(1, 0, 0, 0, 0, 1, 0, 5);
        add(0, 0, 0, 1, 5, 2, 0, 1);
        add(1, 0, 0, 1, 5, 2, 0, 2);
        add(0, 0, 0, 1, 5, 3, 1, 2);
        add(0, 1, 0, 0, 0, 3, 1, 1);
        // simultaneous drain and load
        add(0, 0, 1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 3);
        add(0, 0, 0, 1, 3, 1, 0, 1);
        add(1, 0, 0, 1, 3, 1, 0, 6);
        add(0, 1, 0, 1, 6, 2, 0, 1);
        add(0, 1, 0, 0, 0, 2, 0, 1);

        model_clear();
        repeat (2) tick();
        check("reset.valid", int'(evt_valid), 0);
        check("reset.len", int'(evt_len), 0);
        check("reset.count", int'(run_count), 0);
        check("reset.overrun", int'(overrun), 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            z = tbl[i].zi; evt_ready = tbl[i].ri; clr = tbl[i].ci;
            tick();
            check($sformatf("tbl%0d.valid", i), int'(evt_valid), int'(tbl[i].v));
            if (tbl[i].v) check($sformatf("tbl%0d.len", i), int'(evt_len), tbl[i].len);
            check($sformatf("tbl%0d.count", i), int'(run_count), tbl[i].cnt);
            check($sformatf("tbl%0d.overrun", i), int'(overrun), int'(tbl[i].ovr));
        end
        clr = 1'b0;

        // clr on the completion edge discards the run
        evt_ready = 1'b0;
        z = 1'b1;
        repeat (3) tick();
        z = 1'b0; clr = 1'b1;
        tick();
        check("clr_comp.valid", int'(evt_valid), 0);
        check("clr_comp.count", int'(run_count), 0);
        check("clr_comp.overrun", int'(overrun), 0);
        clr = 1'b0;
        z = 1'b1;
        repeat (9) tick();
        z = 1'b0;
        tick();
        check("after_clr.valid", int'(evt_valid), 1);
        check("after_clr.len", int'(evt_len), 9);
        check("after_clr.count", int'(run_count), 1);
`ifdef SEQ_EVT_TIMESTAMP_EN
        check("after_clr.ts", int'(evt_ts), 10);
`endif

        // reset mid-run acts immediately and discards the partial run
        z = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        model_clear();
        #1;
        check("rst_mid.valid", int'(evt_valid), 0);
        check("rst_mid.len", int'(evt_len), 0);
        check("rst_mid.count", int'(run_count), 0);
        tick();
        reset = 1'b0;
        z = 1'b0;
        repeat (3) tick();
        check("rst_after.valid", int'(evt_valid), 0);
        check("rst_after.count", int'(run_count), 0);

        // saturation on the narrow instance
        z_s = 1'b1;
        repeat (20) tick();
        z_s = 1'b0;
        tick();
        check("sat.valid", int'(valid_s), 1);
        check("sat.len", int'(len_s), 15);
        check("sat.count1", int'(cnt_s), 1);
        for (int r = 0; r < 4; r++) begin
            z_s = 1'b1;
            repeat (2) tick();
            z_s = 1'b0;
            tick();
            if (r == 1) check("sat.count3", int'(cnt_s), 3);
        end
        check("sat.count5", int'(cnt_s), 3);
        check("sat.len2", int'(len_s), 2);

        // randomized traffic against the reference model
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) z = ~z;
            evt_ready = 1'($urandom_range(1));
            clr = ($urandom_range(199) == 0);
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
